io_bus_responder: RTL and testbench
===================================

IO_BUS_RESPONDER -- requirements
Module: io_bus_responder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, event FIFO depth (power of two, 2..16).
REQ-002 Parameter ID_VALUE, default 16'h5A01, value returned by the ID register.
REQ-003 clk_clk  in  1  single clock; all logic on its rising edge.
REQ-004 reset_reset  in  1  reset; synchronous and active-high.
REQ-005 io_address  in  16  byte address from the bus initiator; only bits [3:1] decoded.
REQ-006 io_bus_enable  in  1  transaction request; held by the initiator until acknowledge.
REQ-007 io_byte_enable  in  2  active-high write byte lanes; bit1 = [15:8], bit0 = [7:0].
REQ-008 io_rw  in  1  1 = read, 0 = write.
REQ-009 io_write_data  in  16  write data.
REQ-010 io_read_data  out  16  read data; valid only in the acknowledge cycle, 16'h0000 otherwise.
REQ-011 io_acknowledge  out  1  one-cycle completion pulse.
REQ-012 io_irq  out  1  registered, level interrupt request.
REQ-013 event_valid  in  1  package-sensor event strobe.
REQ-014 event_data  in  16  event payload.

Function
REQ-015 FSM states: IDLE, ACCESS, ACK, TURN; IDLE->ACCESS when io_bus_enable=1; ACCESS->ACK unconditionally; ACK->TURN; TURN->IDLE.
REQ-016 Address, rw, byte enables and write data are latched on the IDLE->ACCESS transition.
REQ-017 Register action occurs in ACCESS; io_acknowledge=1 and io_read_data driven only in ACK, giving a fixed latency of 2 cycles from io_bus_enable sampled to acknowledge.
REQ-018 io_bus_enable is ignored in TURN, so a held request is never acknowledged twice.
REQ-019 Register map (address[3:1]):
  - 0 ID: RO, ID_VALUE.
  - 1 CTRL: RW; bit0 enable, bit1 irq_en, bit2 fifo_clear (self-clearing, reads 0).
  - 2 STATUS: RO; bit0 empty, bit1 full, bit2 overflow (write-1-to-clear via byte lane 0), bits[7:3] count.
  - 3 FIFO_DATA: RO; a read pops the FIFO.
  - 4 EVENT_COUNT: RO; 16-bit count of accepted pushes, wraps 16'hFFFF->0.
  - 5 SCRATCH: RW, per-byte-lane writes.
  - 6..7: reads return 16'h0000; writes are ignored; always acknowledged.
REQ-020 Writes update only lanes whose io_byte_enable bit is 1; io_byte_enable=2'b00 writes nothing but is still acknowledged.
REQ-021 Push occurs when event_valid=1, enable=1 and the FIFO is not full; if full and no pop that cycle, the event is dropped and overflow sets (sticky).
REQ-022 Push and pop in the same cycle both succeed; count is unchanged; a full FIFO with simultaneous pop does not set overflow.
REQ-023 A FIFO_DATA read while empty returns 16'h0000 and leaves pointers and count unchanged.
REQ-024 fifo_clear empties the FIFO and clears overflow in the ACCESS cycle; a push in that same cycle is discarded.
REQ-025 Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-026 io_irq is registered irq_en AND (not empty OR overflow), updated one cycle after its sources change.

Reset
REQ-027 On reset_reset=1 at a clock edge: state=IDLE; io_acknowledge=0; io_read_data=16'h0000; io_irq=0; CTRL=0; SCRATCH=0; EVENT_COUNT=0; overflow=0; FIFO empty.
REQ-028 Reset asserted mid-transaction aborts it with no acknowledge; the initiator re-issues the transaction after reset.

Structure
REQ-029 Package io_responder_pkg holds the register offset constants, the FSM state enum, CTRL/STATUS bit positions and the default ID_VALUE.
REQ-030 The FIFO is the sub-module io_event_fifo (push, pop, clear, data, count, full, empty); decode and FSM logic stay in the top module.

Verification
REQ-031 Read ID after reset -> acknowledge exactly 2 cycles after io_bus_enable, io_read_data=16'h5A01, a single-cycle pulse.
REQ-032 Write SCRATCH 16'hBEEF with byte_enable=2'b01, then read it -> 16'h00EF.
REQ-033 enable=1, push 3 events A1,A2,A3 -> STATUS count=3; three FIFO_DATA reads return A1,A2,A3 in order; a fourth read returns 16'h0000 and STATUS empty=1.
REQ-034 Push 9 events with FIFO_DEPTH=8 -> full=1, overflow=1, EVENT_COUNT=8; with irq_en=1, io_irq=1; W1C of overflow after draining the FIFO -> io_irq=0.
REQ-035 io_bus_enable held high for 6 cycles on a single read -> exactly one acknowledge; a FIFO read pops only once.
REQ-036 Reset asserted in the ACCESS state -> no acknowledge, all outputs at reset values the next cycle.

Source files
------------

// File: rtl/io_responder_pkg.sv
// Shared constants for the IO bus responder: register offsets, CTRL/STATUS
// bit positions, the bus FSM state type and the default ID value.
package io_responder_pkg;

   localparam logic [15:0] ID_VALUE_DEFAULT = 16'h5A01;

   localparam logic [2:0] REG_ID          = 3'd0;
   localparam logic [2:0] REG_CTRL        = 3'd1;
   localparam logic [2:0] REG_STATUS      = 3'd2;
   localparam logic [2:0] REG_FIFO_DATA   = 3'd3;
   localparam logic [2:0] REG_EVENT_COUNT = 3'd4;
   localparam logic [2:0] REG_SCRATCH     = 3'd5;

   localparam int unsigned CTRL_ENABLE_BIT = 0;
   localparam int unsigned CTRL_IRQ_EN_BIT = 1;
   localparam int unsigned CTRL_CLEAR_BIT  = 2;

   localparam int unsigned STAT_EMPTY_BIT    = 0;
   localparam int unsigned STAT_FULL_BIT     = 1;
   localparam int unsigned STAT_OVERFLOW_BIT = 2;
   localparam int unsigned STAT_COUNT_LSB    = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ACK    = 2'd2,
      ST_TURN   = 2'd3
   } bus_state_t;

endpackage

// File: rtl/io_event_fifo.sv
// Event FIFO for package-sensor samples: power-of-two depth, wrapping pointers,
// occupancy count, synchronous clear that overrides push/pop.
module io_event_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk_clk,
   input  logic             reset_reset,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] pop_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   // a full FIFO only takes a push when the same cycle frees a slot
   assign pop_ok  = pop && !empty && !clear;
   assign push_ok = push && (!full || pop_ok) && !clear;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/io_bus_responder.sv
// Bus responder exposing ID/CTRL/STATUS/FIFO/EVENT_COUNT/SCRATCH registers
// behind a fixed-latency request/acknowledge handshake.
//
// state  | meaning
// IDLE   | waiting for io_bus_enable; latches the request on accept
// ACCESS | register read/write side effects happen here
// ACK    | io_acknowledge high, io_read_data valid
// TURN   | turnaround; request input ignored
module io_bus_responder
   import io_responder_pkg::*;
#(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] ID_VALUE   = ID_VALUE_DEFAULT
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic [15:0] io_address,
   input  logic        io_bus_enable,
   input  logic [1:0]  io_byte_enable,
   input  logic        io_rw,
   input  logic [15:0] io_write_data,
   output logic [15:0] io_read_data,
   output logic        io_acknowledge,
   output logic        io_irq,
   input  logic        event_valid,
   input  logic [15:0] event_data
);

   localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

   bus_state_t  state_q, state_d;
   logic [2:0]  addr_q, addr_d;
   logic        rw_q, rw_d;
   logic [1:0]  be_q, be_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic        armed_q, armed_d;
   logic        enable_q, enable_d;
   logic        irq_en_q, irq_en_d;
   logic        overflow_q, overflow_d;
   logic [15:0] scratch_q, scratch_d;
   logic [15:0] event_count_q, event_count_d;
   logic        irq_q, irq_d;

   logic                  fifo_push, fifo_pop, fifo_clear;
   logic [15:0]           fifo_rd_data;
   logic [FIFO_CNT_W-1:0] fifo_count;
   logic                  fifo_full, fifo_empty;
   logic [15:0]           reg_rdata;
   logic                  ovf_w1c, push_req;
   logic                  unused_addr;

   assign unused_addr = ^{io_address[15:4], io_address[0]};

   io_event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_fifo (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .push        (fifo_push),
      .pop         (fifo_pop),
      .clear       (fifo_clear),
      .push_data   (event_data),
      .pop_data    (fifo_rd_data),
      .count       (fifo_count),
      .full        (fifo_full),
      .empty       (fifo_empty)
   );

   always_comb begin
      reg_rdata = 16'h0000;
      case (addr_q)
         REG_ID: reg_rdata = ID_VALUE;
         REG_CTRL: begin
            reg_rdata[CTRL_ENABLE_BIT] = enable_q;
            reg_rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
         end
         REG_STATUS: begin
            reg_rdata[STAT_EMPTY_BIT]           = fifo_empty;
            reg_rdata[STAT_FULL_BIT]            = fifo_full;
            reg_rdata[STAT_OVERFLOW_BIT]        = overflow_q;
            reg_rdata[STAT_COUNT_LSB +: 5]      = 5'(fifo_count);
         end
         REG_FIFO_DATA:   reg_rdata = fifo_empty ? 16'h0000 : fifo_rd_data;
         REG_EVENT_COUNT: reg_rdata = event_count_q;
         REG_SCRATCH:     reg_rdata = scratch_q;
         default:         reg_rdata = 16'h0000;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      rw_d          = rw_q;
      be_d          = be_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      enable_d      = enable_q;
      irq_en_d      = irq_en_q;
      scratch_d     = scratch_q;
      fifo_pop      = 1'b0;
      fifo_clear    = 1'b0;
      ovf_w1c       = 1'b0;
      // a held request must drop once before it can be accepted again
      armed_d       = io_bus_enable ? armed_q : 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (io_bus_enable && armed_q) begin
               state_d = ST_ACCESS;
               addr_d  = io_address[3:1];
               rw_d    = io_rw;
               be_d    = io_byte_enable;
               wdata_d = io_write_data;
               armed_d = 1'b0;
            end
         end
         ST_ACCESS: begin
            state_d = ST_ACK;
            rdata_d = rw_q ? reg_rdata : 16'h0000;
            if (rw_q) begin
               fifo_pop = (addr_q == REG_FIFO_DATA) && !fifo_empty;
            end else begin
               case (addr_q)
                  REG_CTRL: begin
                     if (be_q[0]) begin
                        enable_d   = wdata_q[CTRL_ENABLE_BIT];
                        irq_en_d   = wdata_q[CTRL_IRQ_EN_BIT];
                        fifo_clear = wdata_q[CTRL_CLEAR_BIT];
                     end
                  end
                  REG_STATUS: ovf_w1c = be_q[0] && wdata_q[STAT_OVERFLOW_BIT];
                  REG_SCRATCH: begin
                     if (be_q[0]) scratch_d[7:0]  = wdata_q[7:0];
                     if (be_q[1]) scratch_d[15:8] = wdata_q[15:8];
                  end
                  default: ;
               endcase
            end
         end
         ST_ACK:  state_d = ST_TURN;
         ST_TURN: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // events arriving during a clear are discarded, not counted as overflow
      push_req      = event_valid && enable_q && !fifo_clear;
      fifo_push     = push_req && (!fifo_full || fifo_pop);
      event_count_d = event_count_q + {15'd0, fifo_push};
      if (fifo_clear)
         overflow_d = 1'b0;
      else if (push_req && fifo_full && !fifo_pop)
         overflow_d = 1'b1;
      else if (ovf_w1c)
         overflow_d = 1'b0;
      else
         overflow_d = overflow_q;

      irq_d = irq_en_q && (!fifo_empty || overflow_q);
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         rw_q          <= 1'b0;
         be_q          <= '0;
         wdata_q       <= '0;
         rdata_q       <= '0;
         armed_q       <= 1'b1;
         enable_q      <= 1'b0;
         irq_en_q      <= 1'b0;
         overflow_q    <= 1'b0;
         scratch_q     <= '0;
         event_count_q <= '0;
         irq_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         rw_q          <= rw_d;
         be_q          <= be_d;
         wdata_q       <= wdata_d;
         rdata_q       <= rdata_d;
         armed_q       <= armed_d;
         enable_q      <= enable_d;
         irq_en_q      <= irq_en_d;
         overflow_q    <= overflow_d;
         scratch_q     <= scratch_d;
         event_count_q <= event_count_d;
         irq_q         <= irq_d;
      end
   end

   assign io_acknowledge = (state_q == ST_ACK);
   assign io_read_data   = io_acknowledge ? rdata_q : 16'h0000;
   assign io_irq         = irq_q;

endmodule

// File: tb/tb_io_bus_responder.sv
// Scoreboard bench for io_bus_responder: transactions queue their expected
// read data, an independent monitor checks every acknowledge against it.
module tb_io_bus_responder;

   logic        clk_clk = 1'b0;
   logic        reset_reset;
   logic [15:0] io_address;
   logic        io_bus_enable;
   logic [1:0]  io_byte_enable;
   logic        io_rw;
   logic [15:0] io_write_data;
   logic [15:0] io_read_data;
   logic        io_acknowledge;
   logic        io_irq;
   logic        event_valid;
   logic [15:0] event_data;

   typedef struct {
      logic [15:0] data;
      logic        chk;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks  = 0;
   int   n_fail    = 0;
   int   ack_count = 0;
   logic mon_en    = 1'b0;

   localparam logic [2:0] A_ID = 3'd0, A_CTRL = 3'd1, A_STAT = 3'd2, A_FIFO = 3'd3;
   localparam logic [2:0] A_ECNT = 3'd4, A_SCR = 3'd5;

   io_bus_responder dut (
      .clk_clk        (clk_clk),
      .reset_reset    (reset_reset),
      .io_address     (io_address),
      .io_bus_enable  (io_bus_enable),
      .io_byte_enable (io_byte_enable),
      .io_rw          (io_rw),
      .io_write_data  (io_write_data),
      .io_read_data   (io_read_data),
      .io_acknowledge (io_acknowledge),
      .io_irq         (io_irq),
      .event_valid    (event_valid),
      .event_data     (event_data)
   );

   always #5 clk_clk = ~clk_clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk_clk) begin
      if (mon_en) begin
         if (io_acknowledge) begin
            exp_t e;
            ack_count++;
            check("ack_expected", {15'd0, exp_q.size() != 0}, 16'h0001);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               if (e.chk) check(e.name, io_read_data, e.data);
            end
         end else begin
            check("rdata_idle", io_read_data, 16'h0000);
         end
      end
   end

   task automatic xfer(input logic rw, input logic [2:0] idx, input logic [1:0] be,
                       input logic [15:0] wd, input logic [15:0] exp, input string name);
      exp_t e;
      int   cyc;
      e.data = exp; e.chk = rw; e.name = name;
      exp_q.push_back(e);
      @(negedge clk_clk);
      io_bus_enable  = 1'b1;
      io_rw          = rw;
      io_address     = {12'hA5C, idx, 1'b0};
      io_byte_enable = be;
      io_write_data  = wd;
      cyc = 0;
      do begin
         @(negedge clk_clk);
         cyc++;
      end while (!io_acknowledge && cyc < 10);
      check({name, "_latency"}, 16'(cyc), 16'd2);
      io_bus_enable = 1'b0;
      @(negedge clk_clk);
   endtask

   task automatic rd(input logic [2:0] idx, input logic [15:0] exp, input string name);
      xfer(1'b1, idx, 2'b00, 16'h0000, exp, name);
   endtask

   task automatic wr(input logic [2:0] idx, input logic [1:0] be, input logic [15:0] wd);
      xfer(1'b0, idx, be, wd, 16'h0000, "write");
   endtask

   task automatic push_event(input logic [15:0] d);
      @(negedge clk_clk);
      event_valid = 1'b1;
      event_data  = d;
      @(negedge clk_clk);
      event_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a0;
      reset_reset = 1'b1; io_address = '0; io_bus_enable = 1'b0; io_byte_enable = '0;
      io_rw = 1'b0; io_write_data = '0; event_valid = 1'b0; event_data = '0;
      repeat (3) @(negedge clk_clk);
      check("reset_ack", {15'd0, io_acknowledge}, 16'h0000);
      check("reset_rdata", io_read_data, 16'h0000);
      check("reset_irq", {15'd0, io_irq}, 16'h0000);
      mon_en = 1'b1;
      reset_reset = 1'b0;

      rd(A_ID, 16'h5A01, "id");
      rd(A_CTRL, 16'h0000, "ctrl_rst");
      rd(A_SCR, 16'h0000, "scratch_rst");
      rd(A_ECNT, 16'h0000, "ecnt_rst");
      rd(A_STAT, 16'h0001, "status_rst");

      wr(A_SCR, 2'b01, 16'hBEEF);
      rd(A_SCR, 16'h00EF, "scratch_lane0");
      wr(A_SCR, 2'b10, 16'h1234);
      rd(A_SCR, 16'h12EF, "scratch_lane1");
      wr(A_SCR, 2'b00, 16'h55AA);
      rd(A_SCR, 16'h12EF, "scratch_no_lane");
      wr(3'd7, 2'b11, 16'hFFFF);
      rd(3'd7, 16'h0000, "reserved7");
      rd(3'd6, 16'h0000, "reserved6");
      rd(A_SCR, 16'h12EF, "scratch_after_rsvd");

      push_event(16'h0099);
      rd(A_STAT, 16'h0001, "status_disabled_push");
      wr(A_CTRL, 2'b01, 16'h0001);
      push_event(16'h00A1); push_event(16'h00A2); push_event(16'h00A3);
      rd(A_STAT, 16'h0018, "status_cnt3");
      rd(A_FIFO, 16'h00A1, "fifo_a1");
      rd(A_FIFO, 16'h00A2, "fifo_a2");
      rd(A_FIFO, 16'h00A3, "fifo_a3");
      rd(A_FIFO, 16'h0000, "fifo_empty_read");
      rd(A_STAT, 16'h0001, "status_empty");
      rd(A_ECNT, 16'h0003, "ecnt3");

      wr(A_CTRL, 2'b01, 16'h0003);
      check("irq_idle", {15'd0, io_irq}, 16'h0000);
      for (int i = 0; i < 9; i++) push_event(16'hE000 + 16'(i));
      rd(A_STAT, 16'h0046, "status_full_ovf");
      rd(A_ECNT, 16'h000B, "ecnt_after_ovf");
      check("irq_full", {15'd0, io_irq}, 16'h0001);
      for (int i = 0; i < 8; i++) rd(A_FIFO, 16'hE000 + 16'(i), "fifo_drain_e");
      rd(A_STAT, 16'h0005, "status_empty_ovf");
      check("irq_ovf_only", {15'd0, io_irq}, 16'h0001);
      wr(A_STAT, 2'b01, 16'h0004);
      rd(A_STAT, 16'h0001, "status_w1c");
      check("irq_after_w1c", {15'd0, io_irq}, 16'h0000);

      push_event(16'h00B1); push_event(16'h00B2);
      begin
         exp_t e;
         e.data = 16'h00B1; e.chk = 1'b1; e.name = "held_read";
         exp_q.push_back(e);
      end
      a0 = ack_count;
      @(negedge clk_clk);
      io_bus_enable = 1'b1; io_rw = 1'b1; io_address = {12'h000, A_FIFO, 1'b0};
      repeat (6) @(negedge clk_clk);
      io_bus_enable = 1'b0;
      repeat (3) @(negedge clk_clk);
      check("held_acks", 16'(ack_count - a0), 16'd1);
      rd(A_STAT, 16'h0008, "status_held_popped_once");
      rd(A_FIFO, 16'h00B2, "fifo_b2");
      rd(A_ECNT, 16'h000D, "ecnt13");

      for (int i = 0; i < 9; i++) push_event(16'hD000 + 16'(i));
      rd(A_STAT, 16'h0046, "status_full_ovf2");
      wr(A_CTRL, 2'b01, 16'h0007);
      rd(A_STAT, 16'h0001, "status_cleared");
      rd(A_CTRL, 16'h0003, "ctrl_clear_selfclr");
      rd(A_ECNT, 16'h0015, "ecnt21");
      check("irq_after_clear", {15'd0, io_irq}, 16'h0000);

      for (int i = 0; i < 8; i++) push_event(16'hF000 + 16'(i));
      rd(A_STAT, 16'h0042, "status_full_no_ovf");
      fork
         rd(A_FIFO, 16'hF000, "fifo_pop_push_full");
         begin
            @(negedge clk_clk);
            @(negedge clk_clk);
            event_valid = 1'b1; event_data = 16'hF008;
            @(negedge clk_clk);
            event_valid = 1'b0;
         end
      join
      rd(A_STAT, 16'h0042, "status_after_pop_push");
      rd(A_ECNT, 16'h001E, "ecnt30");
      for (int i = 1; i < 9; i++) rd(A_FIFO, 16'hF000 + 16'(i), "fifo_drain_f");
      rd(A_STAT, 16'h0001, "status_drained_f");

      push_event(16'h0C01);
      repeat (2) @(negedge clk_clk);
      check("irq_pre_reset", {15'd0, io_irq}, 16'h0001);
      @(negedge clk_clk);
      io_bus_enable = 1'b1; io_rw = 1'b1; io_address = {12'h000, A_ID, 1'b0};
      @(negedge clk_clk);
      reset_reset = 1'b1; io_bus_enable = 1'b0;
      @(negedge clk_clk);
      check("midreset_ack", {15'd0, io_acknowledge}, 16'h0000);
      check("midreset_rdata", io_read_data, 16'h0000);
      check("midreset_irq", {15'd0, io_irq}, 16'h0000);
      reset_reset = 1'b0;
      rd(A_CTRL, 16'h0000, "ctrl_post_reset");
      rd(A_SCR, 16'h0000, "scratch_post_reset");
      rd(A_ECNT, 16'h0000, "ecnt_post_reset");
      rd(A_STAT, 16'h0001, "status_post_reset");
      rd(A_ID, 16'h5A01, "id_post_reset");

      repeat (5) @(negedge clk_clk);
      check("queue_drained", 16'(exp_q.size()), 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
